// File: rtl/hazard_pkg.sv
// Shared processor definitions for the load-use hazard unit.
// Scoreboard entry layout, register width and stall-depth limit.
package hazard_pkg;

   localparam int HU_REG_BITS  = 4;
   localparam int HU_DEPTH_MAX = 2;

   typedef struct packed {
      logic                   valid;
      logic                   wr;
      logic [HU_REG_BITS-1:0] rt;
      logic                   load;
   } sb_entry_t;

   // A source depends on an entry when it is read, is not r0,
   // and names the register a valid in-flight writer targets.
   function automatic logic src_hit(
      input logic                   used,
      input logic [HU_REG_BITS-1:0] src,
      input sb_entry_t              e
   );
      return used && (src != '0) && e.valid && e.wr && (e.rt == src);
   endfunction

endpackage

// File: rtl/sb_stage.sv
// One registered scoreboard entry.
// A bubble request loads an invalid entry instead of the input.
module sb_stage
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      bubble_i,
   input  sb_entry_t entry_i,
   output sb_entry_t entry_o
);

   sb_entry_t entry_q;
   sb_entry_t entry_d;

   // Select the incoming entry or a bubble.
   always_comb begin
      entry_d = entry_i;
      if (bubble_i) entry_d = '0;
   end

   // Entry register, cleared to invalid on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) entry_q <= '0;
      else        entry_q <= entry_d;
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use hazard detection with an EX/MEM scoreboard.
// ALU results are forwarded; only loads in flight cause stalls.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_BITS = HU_REG_BITS,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dec_valid,
   input  logic [REG_BITS-1:0] dec_ra,
   input  logic [REG_BITS-1:0] dec_rb,
   input  logic                dec_use_ra,
   input  logic                dec_use_rb,
   input  logic                dec_wr,
   input  logic [REG_BITS-1:0] dec_rt,
   input  logic                dec_load,
   input  logic                redirect,
   output logic                stall,
   output logic                flush,
   output logic                issue,
   output logic [1:0]          stall_depth,
   output logic [CNT_BITS-1:0] stall_count
);

   sb_entry_t dec_e;
   sb_entry_t ex_e;
   sb_entry_t mem_e;
   logic      ld_hit;

   logic [1:0]          depth_q;
   logic [1:0]          depth_d;
   logic [CNT_BITS-1:0] cnt_q;
   logic [CNT_BITS-1:0] cnt_d;

   assign dec_e = '{valid: dec_valid, wr: dec_wr,
                    rt: dec_rt, load: dec_load};

   // EX bubbles whenever nothing issues, including on redirect.
   sb_stage u_ex (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (~issue),
      .entry_i  (dec_e),
      .entry_o  (ex_e)
   );

   // MEM always advances the previous EX entry.
   sb_stage u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (1'b0),
      .entry_i  (ex_e),
      .entry_o  (mem_e)
   );

   // Hazard detect and handshake outputs; redirect wins over stall.
   always_comb begin
      ld_hit = (src_hit(dec_use_ra, dec_ra, ex_e)  && ex_e.load)
            || (src_hit(dec_use_rb, dec_rb, ex_e)  && ex_e.load)
            || (src_hit(dec_use_ra, dec_ra, mem_e) && mem_e.load)
            || (src_hit(dec_use_rb, dec_rb, mem_e) && mem_e.load);
      stall  = rst_n & dec_valid & ~redirect & ld_hit;
      flush  = rst_n & redirect;
      issue  = rst_n & dec_valid & ~redirect & ~stall;
   end

   // Stall run length and saturating stall total.
   always_comb begin
      depth_d = '0;
      cnt_d   = cnt_q;
      if (stall) begin
         if (depth_q == 2'(HU_DEPTH_MAX)) depth_d = depth_q;
         else                             depth_d = depth_q + 2'd1;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         depth_q <= '0;
         cnt_q   <= '0;
      end else begin
         depth_q <= depth_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_depth = depth_d;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit.
// Directed load-use scenarios followed by randomized traffic.
module tb_hazard_unit;

   localparam int CB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          dec_valid;
   logic [3:0]    dec_ra;
   logic [3:0]    dec_rb;
   logic          dec_use_ra;
   logic          dec_use_rb;
   logic          dec_wr;
   logic [3:0]    dec_rt;
   logic          dec_load;
   logic          redirect;
   logic          stall;
   logic          flush;
   logic          issue;
   logic [1:0]    stall_depth;
   logic [CB-1:0] stall_count;

   always #5 clk = ~clk;

   hazard_unit #(.REG_BITS(4), .CNT_BITS(CB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dec_valid   (dec_valid),
      .dec_ra      (dec_ra),
      .dec_rb      (dec_rb),
      .dec_use_ra  (dec_use_ra),
      .dec_use_rb  (dec_use_rb),
      .dec_wr      (dec_wr),
      .dec_rt      (dec_rt),
      .dec_load    (dec_load),
      .redirect    (redirect),
      .stall       (stall),
      .flush       (flush),
      .issue       (issue),
      .stall_depth (stall_depth),
      .stall_count (stall_count)
   );

   int checks   = 0;
   int failures = 0;

   // Reference: list of issued instructions tagged with issue cycle.
   typedef struct {
      int cyc;
      bit wr;
      bit load;
      int rt;
   } iss_t;

   iss_t hist[$];
   int   now_c = 0;
   int   run   = 0;
   int   m_cnt = 0;
   bit   e_stall;
   bit   e_flush;
   bit   e_issue;
   int   e_depth;
   bit   hold;

   // A load issued one or two cycles ago has no data to forward yet.
   function automatic bit load_pending(int r);
      if (r == 0) return 1'b0;
      foreach (hist[i])
         if (hist[i].cyc >= now_c - 2 && hist[i].load &&
             hist[i].wr && hist[i].rt == r)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drv(bit v, int ra, int rb, bit ua, bit ub,
                      bit wr, int rt, bit ld, bit rd);
      dec_valid  = v;
      dec_ra     = 4'(ra);
      dec_rb     = 4'(rb);
      dec_use_ra = ua;
      dec_use_rb = ub;
      dec_wr     = wr;
      dec_rt     = 4'(rt);
      dec_load   = ld;
      redirect   = rd;
   endtask

   task automatic model_eval();
      bit hz;
      hz = (dec_use_ra && load_pending(int'(dec_ra))) ||
           (dec_use_rb && load_pending(int'(dec_rb)));
      e_stall = rst_n && dec_valid && !redirect && hz;
      e_flush = rst_n && redirect;
      e_issue = rst_n && dec_valid && !redirect && !e_stall;
      e_depth = e_stall ? ((run + 1 > 2) ? 2 : run + 1) : 0;
   endtask

   // Compare all outputs to the model, then advance one clock.
   task automatic cyc(string tag);
      model_eval();
      #1;
      check({tag, ".stall"}, stall, e_stall);
      check({tag, ".flush"}, flush, e_flush);
      check({tag, ".issue"}, issue, e_issue);
      check({tag, ".depth"}, stall_depth, e_depth);
      check({tag, ".count"}, stall_count, m_cnt);
      @(posedge clk);
      if (!rst_n) begin
         hist.delete();
         run   = 0;
         m_cnt = 0;
      end else begin
         if (e_stall) begin
            run++;
            if (m_cnt < 2**CB - 1) m_cnt++;
         end else begin
            run = 0;
         end
         if (e_issue)
            hist.push_back('{now_c, dec_wr, dec_load, int'(dec_rt)});
      end
      now_c++;
      while (hist.size() > 0 && hist[0].cyc < now_c - 2)
         void'(hist.pop_front());
      @(negedge clk);
   endtask

   // Directed expectations for the current cycle.
   task automatic dchk(string tag, bit s, bit f, bit i, int d);
      #1;
      check({tag, ".d_stall"}, stall, s);
      check({tag, ".d_flush"}, flush, f);
      check({tag, ".d_issue"}, issue, i);
      check({tag, ".d_depth"}, stall_depth, d);
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ld_r(int rt);
      drv(1, 1, 0, 1, 0, 1, rt, 1, 0);
   endtask

   task automatic use_r(int r, int rt);
      drv(1, r, r, 1, 1, 1, rt, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);

      // Outputs are held low while in reset.
      drv(1, 3, 3, 1, 1, 1, 3, 1, 1);
      dchk("rst_a", 0, 0, 0, 0);
      cyc("rst_a");
      ld_r(3);
      cyc("rst_b");
      rst_n = 1'b1;
      idle();
      cyc("idle0");

      // Dependent instruction right behind a load.
      ld_r(3);
      cyc("lu_ld");
      use_r(3, 4);
      dchk("lu_s1", 1, 0, 0, 1);
      cyc("lu_s1");
      dchk("lu_s2", 1, 0, 0, 2);
      cyc("lu_s2");
      dchk("lu_go", 0, 0, 1, 0);
      cyc("lu_go");
      check("lu_cnt", stall_count, 2);
      idle();
      cyc("idle1");
      cyc("idle2");

      // One independent instruction between load and use.
      ld_r(3);
      cyc("gap_ld");
      drv(1, 1, 2, 1, 1, 1, 5, 0, 0);
      cyc("gap_ind");
      use_r(3, 6);
      dchk("gap_s1", 1, 0, 0, 1);
      cyc("gap_s1");
      dchk("gap_go", 0, 0, 1, 0);
      cyc("gap_go");

      // ALU producer is forwarded.
      drv(1, 1, 2, 1, 1, 1, 5, 0, 0);
      dchk("alu_w", 0, 0, 1, 0);
      cyc("alu_w");
      use_r(5, 7);
      dchk("alu_u", 0, 0, 1, 0);
      cyc("alu_u");

      // Register zero never blocks.
      ld_r(0);
      cyc("r0_ld");
      use_r(0, 7);
      dchk("r0_u", 0, 0, 1, 0);
      cyc("r0_u");
      idle();
      cyc("idle3");
      cyc("idle4");

      // Redirect during the first stall cycle.
      ld_r(3);
      cyc("rd_ld");
      drv(1, 3, 0, 1, 0, 1, 6, 1, 1);
      dchk("rd_same", 0, 1, 0, 0);
      cyc("rd_same");
      use_r(6, 8);
      dchk("rd_next", 0, 0, 1, 0);
      cyc("rd_next");
      idle();
      cyc("idle5");
      cyc("idle6");

      // Reset in the middle of a stall run.
      ld_r(3);
      cyc("rs_ld");
      use_r(3, 4);
      dchk("rs_s1", 1, 0, 0, 1);
      cyc("rs_s1");
      rst_n = 1'b0;
      dchk("rs_in", 0, 0, 0, 0);
      cyc("rs_in");
      rst_n = 1'b1;
      dchk("rs_out", 0, 0, 1, 0);
      check("rs_cnt", stall_count, 0);
      cyc("rs_out");
      idle();
      cyc("idle7");
      cyc("idle8");

      // Drive the stall total into saturation.
      for (int k = 0; k < 9; k++) begin
         ld_r(3);
         cyc("sat_ld");
         use_r(3, 4);
         cyc("sat_s1");
         cyc("sat_s2");
         cyc("sat_go");
      end
      check("sat_full", stall_count, 2**CB - 1);
      ld_r(3);
      cyc("sat_ld2");
      use_r(3, 4);
      cyc("sat_s1b");
      cyc("sat_s2b");
      check("sat_hold", stall_count, 2**CB - 1);
      idle();
      cyc("idle9");

      // Randomized traffic; decode holds while stalled.
      hold = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!hold)
            drv($urandom_range(0, 9) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                $urandom_range(0, 2) == 0, 0);
         redirect = $urandom_range(0, 9) == 0;
         rst_n    = $urandom_range(0, 49) != 0;
         cyc("rnd");
         hold = e_stall;
      end
      rst_n = 1'b1;
      idle();
      cyc("end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
